// File: rtl/mem_burst_master_if.sv
// Command, stream and memory-port bundle for mem_burst_master.
// The master modport is the burst engine's view; slave is the surrounding system.
interface mem_burst_master_if #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 1024
);
  localparam int ADDR_W = $clog2(HEIGHT);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W:0]   cmd_len;

  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;
  logic              rd_last;
  logic              rd_ready;

  logic [WIDTH-1:0]  wr_data;
  logic              wr_valid;
  logic              wr_ready;

  logic              done;

  logic [ADDR_W-1:0] mem_read_addr;
  logic              mem_read_en;
  logic [WIDTH-1:0]  mem_qout;
  logic [ADDR_W-1:0] mem_write_addr;
  logic [WIDTH-1:0]  mem_din;
  logic              mem_write_en;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready,
    output rd_data, rd_valid, rd_last,
    input  rd_ready,
    input  wr_data, wr_valid,
    output wr_ready,
    output done,
    output mem_read_addr, mem_read_en,
    input  mem_qout,
    output mem_write_addr, mem_din, mem_write_en
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready,
    input  rd_data, rd_valid, rd_last,
    output rd_ready,
    output wr_data, wr_valid,
    input  wr_ready,
    input  done,
    input  mem_read_addr, mem_read_en,
    output mem_qout,
    input  mem_write_addr, mem_din, mem_write_en
  );
endinterface

// File: rtl/mem_burst_master.sv
// Burst initiator for the pseudo-2-port memory: one command streams a run of
// consecutive words out (read) or in (write), wrapping at the memory depth.
module mem_burst_master #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 1024
) (
  input  logic                clk,
  input  logic                arst_in,
  mem_burst_master_if.master  bus
);
  localparam int ADDR_W = $clog2(HEIGHT);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_next;
  logic [ADDR_W:0]   issued;
  logic [ADDR_W:0]   remaining;
  logic [WIDTH-1:0]  rd_data_q;
  logic              rd_valid_q;
  logic              rd_last_q;
  logic              done_q;
  logic              read_fire;
  logic              read_hs;
  logic              write_fire;

  // Explicit wrap so non-power-of-2 depths step HEIGHT-1 -> 0.
  assign addr_next = (addr == ADDR_W'(HEIGHT - 1)) ? '0 : addr + ADDR_W'(1);

  // A read is only issued when the output register is free or being drained,
  // so every enable corresponds to exactly one delivered word.
  assign read_fire  = (state == READ) && (issued < remaining) &&
                      (!rd_valid_q || bus.rd_ready);
  assign read_hs    = rd_valid_q && bus.rd_ready;
  assign write_fire = (state == WRITE) && (remaining != '0) && bus.wr_valid;

  assign bus.cmd_ready      = (state == IDLE) && !arst_in;
  assign bus.rd_data        = rd_data_q;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.rd_last        = rd_last_q;
  assign bus.wr_ready       = (state == WRITE) && (remaining != '0);
  assign bus.done           = done_q;
  assign bus.mem_read_addr  = addr;
  assign bus.mem_read_en    = read_fire;
  assign bus.mem_write_addr = addr;
  assign bus.mem_din        = bus.wr_data;
  assign bus.mem_write_en   = write_fire;

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state      <= IDLE;
      addr       <= '0;
      issued     <= '0;
      remaining  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            addr      <= bus.cmd_addr;
            remaining <= bus.cmd_len;
            issued    <= '0;
            if (bus.cmd_len == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= bus.cmd_write ? WRITE : READ;
            end
          end
        end

        READ: begin
          if (read_fire) begin
            rd_data_q  <= bus.mem_qout;
            rd_valid_q <= 1'b1;
            rd_last_q  <= (issued == remaining - (ADDR_W+1)'(1));
            issued     <= issued + (ADDR_W+1)'(1);
            addr       <= addr_next;
          end else if (read_hs) begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            if (rd_last_q) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end

        WRITE: begin
          if (write_fire) begin
            addr      <= addr_next;
            remaining <= remaining - (ADDR_W+1)'(1);
            if (remaining == (ADDR_W+1)'(1)) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_burst_master.sv
// Directed self-checking bench for mem_burst_master with a 16-deep memory model.
module tb_mem_burst_master;
  localparam int WIDTH  = 16;
  localparam int HEIGHT = 16;

  logic clk = 1'b0;
  logic arst_in;
  logic preload;

  mem_burst_master_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) bus ();

  mem_burst_master #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk     (clk),
    .arst_in (arst_in),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge.
  logic [15:0] mem [0:15];
  assign bus.mem_qout = mem[bus.mem_read_addr];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++)
        mem[i] <= (i >= 10 && i <= 13) ? 16'(16'h00A0 + i - 10) : 16'(16'h5500 + i);
    end else if (bus.mem_write_en) begin
      mem[bus.mem_write_addr] <= bus.mem_din;
    end
  end

  int          read_en_count  = 0;
  int          write_en_count = 0;
  int          done_count     = 0;
  int          rd_log_count   = 0;
  logic [15:0] rd_log [0:63];

  always @(posedge clk) begin
    if (!arst_in) begin
      if (bus.mem_read_en)  read_en_count++;
      if (bus.mem_write_en) write_en_count++;
      if (bus.done)         done_count++;
      if (bus.rd_valid && bus.rd_ready && rd_log_count < 64) begin
        rd_log[rd_log_count] = bus.rd_data;
        rd_log_count++;
      end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Plain read burst, rd_ready held high, cycles c0..c6 after acceptance.
  bit   [0:6]  rd1_valid = 7'b0111100;
  bit   [0:6]  rd1_en    = 7'b1111000;
  bit   [0:6]  rd1_last  = 7'b0000100;
  bit   [0:6]  rd1_done  = 7'b0000010;
  bit   [0:6]  rd1_crdy  = 7'b0000001;
  logic [15:0] rd1_data  [0:6] = '{16'h0, 16'hA0, 16'hA1, 16'hA2, 16'hA3, 16'h0, 16'h0};
  logic [3:0]  rd1_addr  [0:6] = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd14, 4'd14};

  // Read burst under backpressure, cycles c0..c8.
  bit   [0:8]  bp_rdy    = 9'b100101111;
  bit   [0:8]  bp_valid  = 9'b011111110;
  bit   [0:8]  bp_en     = 9'b100101100;
  bit   [0:8]  bp_last   = 9'b000000010;
  bit   [0:8]  bp_done   = 9'b000000001;
  logic [15:0] bp_data   [0:8] = '{16'h0, 16'hA0, 16'hA0, 16'hA0, 16'hA1, 16'hA1, 16'hA2, 16'hA3, 16'h0};

  // Gapped write burst at addr 14 crossing the wrap, cycles c0..c7.
  bit   [0:7]  wr_v      = 8'b10110110;
  logic [15:0] wr_d      [0:7] = '{16'd1, 16'd0, 16'd2, 16'd3, 16'd0, 16'd4, 16'd5, 16'd0};
  bit   [0:7]  wr_rdy    = 8'b11111100;
  bit   [0:7]  wr_en     = 8'b10110100;
  logic [3:0]  wr_addr   [0:7] = '{4'd14, 4'd15, 4'd15, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2};
  bit   [0:7]  wr_done   = 8'b00000010;

  int base_rd_en;
  int base_wr_en;
  int base_done;
  int base_log;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Offers a command in the current cycle; returns one tick into cycle c0.
  task automatic applyStimulus(input logic wr, input logic [3:0] a, input logic [4:0] len);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_len   = len;
    @(negedge clk);
    checkOutput("cmd_ready_before_accept", bus.cmd_ready, 1);
    next_cycle();
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    arst_in       = 1'b1;
    preload       = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.rd_ready  = 1'b0;
    bus.wr_data   = '0;
    bus.wr_valid  = 1'b0;

    #2;
    checkOutput("reset_cmd_ready", bus.cmd_ready, 0);
    checkOutput("reset_rd_valid", bus.rd_valid, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_wr_ready", bus.wr_ready, 0);
    checkOutput("reset_mem_read_en", bus.mem_read_en, 0);
    checkOutput("reset_rd_data", bus.rd_data, 0);

    @(posedge clk);
    @(negedge clk);
    arst_in = 1'b0;
    preload = 1'b0;
    #1;
    checkOutput("post_reset_cmd_ready", bus.cmd_ready, 1);
    checkOutput("post_reset_done", bus.done, 0);
    next_cycle();

    // Plain read burst.
    $display("[TB] read burst addr=10 len=4");
    base_rd_en = read_en_count; base_done = done_count; base_log = rd_log_count;
    bus.rd_ready = 1'b1;
    applyStimulus(1'b0, 4'd10, 5'd4);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rd1_valid_c%0d", c), bus.rd_valid, rd1_valid[c]);
      checkOutput($sformatf("rd1_en_c%0d", c), bus.mem_read_en, rd1_en[c]);
      checkOutput($sformatf("rd1_done_c%0d", c), bus.done, rd1_done[c]);
      checkOutput($sformatf("rd1_cmd_ready_c%0d", c), bus.cmd_ready, rd1_crdy[c]);
      checkOutput($sformatf("rd1_raddr_c%0d", c), bus.mem_read_addr, rd1_addr[c]);
      if (rd1_valid[c]) begin
        checkOutput($sformatf("rd1_data_c%0d", c), bus.rd_data, rd1_data[c]);
        checkOutput($sformatf("rd1_last_c%0d", c), bus.rd_last, rd1_last[c]);
      end
      next_cycle();
    end
    checkOutput("rd1_read_en_total", read_en_count - base_rd_en, 4);
    checkOutput("rd1_done_total", done_count - base_done, 1);
    checkOutput("rd1_words", rd_log_count - base_log, 4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("rd1_word%0d", i), rd_log[base_log + i], 16'hA0 + i);

    // Same burst under backpressure.
    $display("[TB] read burst with backpressure");
    base_rd_en = read_en_count; base_done = done_count; base_log = rd_log_count;
    applyStimulus(1'b0, 4'd10, 5'd4);
    for (int c = 0; c < 9; c++) begin
      bus.rd_ready = bp_rdy[c];
      @(negedge clk);
      checkOutput($sformatf("bp_valid_c%0d", c), bus.rd_valid, bp_valid[c]);
      checkOutput($sformatf("bp_en_c%0d", c), bus.mem_read_en, bp_en[c]);
      checkOutput($sformatf("bp_done_c%0d", c), bus.done, bp_done[c]);
      if (bp_valid[c]) begin
        checkOutput($sformatf("bp_data_c%0d", c), bus.rd_data, bp_data[c]);
        checkOutput($sformatf("bp_last_c%0d", c), bus.rd_last, bp_last[c]);
      end
      next_cycle();
    end
    checkOutput("bp_read_en_total", read_en_count - base_rd_en, 4);
    checkOutput("bp_words", rd_log_count - base_log, 4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("bp_word%0d", i), rd_log[base_log + i], 16'hA0 + i);
    bus.rd_ready = 1'b0;

    // Gapped write across the top of memory.
    $display("[TB] write burst addr=14 len=4 with wrap");
    base_rd_en = read_en_count; base_done = done_count;
    applyStimulus(1'b1, 4'd14, 5'd4);
    for (int c = 0; c < 8; c++) begin
      bus.wr_valid = wr_v[c];
      bus.wr_data  = wr_d[c];
      @(negedge clk);
      checkOutput($sformatf("wr_ready_c%0d", c), bus.wr_ready, wr_rdy[c]);
      checkOutput($sformatf("wr_en_c%0d", c), bus.mem_write_en, wr_en[c]);
      checkOutput($sformatf("wr_addr_c%0d", c), bus.mem_write_addr, wr_addr[c]);
      checkOutput($sformatf("wr_done_c%0d", c), bus.done, wr_done[c]);
      if (wr_en[c])
        checkOutput($sformatf("wr_din_c%0d", c), bus.mem_din, wr_d[c]);
      next_cycle();
    end
    bus.wr_valid = 1'b0;
    checkOutput("wr_mem14", mem[14], 16'd1);
    checkOutput("wr_mem15", mem[15], 16'd2);
    checkOutput("wr_mem0", mem[0], 16'd3);
    checkOutput("wr_mem1", mem[1], 16'd4);
    checkOutput("wr_mem2_untouched", mem[2], 16'h5502);
    checkOutput("wr_no_reads", read_en_count - base_rd_en, 0);
    checkOutput("wr_done_total", done_count - base_done, 1);

    // Zero-length commands in both directions.
    $display("[TB] zero-length commands");
    base_rd_en = read_en_count; base_wr_en = write_en_count; base_done = done_count;
    bus.rd_ready = 1'b1;
    applyStimulus(1'b0, 4'd3, 5'd0);
    @(negedge clk);
    checkOutput("zr_done", bus.done, 1);
    checkOutput("zr_cmd_ready", bus.cmd_ready, 0);
    checkOutput("zr_read_en", bus.mem_read_en, 0);
    checkOutput("zr_rd_valid", bus.rd_valid, 0);
    next_cycle();
    @(negedge clk);
    checkOutput("zr_cmd_ready_back", bus.cmd_ready, 1);
    checkOutput("zr_done_low", bus.done, 0);
    next_cycle();
    bus.wr_valid = 1'b1;
    bus.wr_data  = 16'hBEEF;
    applyStimulus(1'b1, 4'd3, 5'd0);
    @(negedge clk);
    checkOutput("zw_done", bus.done, 1);
    checkOutput("zw_wr_ready", bus.wr_ready, 0);
    checkOutput("zw_write_en", bus.mem_write_en, 0);
    next_cycle();
    @(negedge clk);
    checkOutput("zw_cmd_ready_back", bus.cmd_ready, 1);
    next_cycle();
    bus.wr_valid = 1'b0;
    checkOutput("z_read_en_total", read_en_count - base_rd_en, 0);
    checkOutput("z_write_en_total", write_en_count - base_wr_en, 0);
    checkOutput("z_done_total", done_count - base_done, 2);
    checkOutput("z_mem3_untouched", mem[3], 16'h5503);

    // Reset in the middle of a 5-word read, after two words handed over.
    $display("[TB] reset mid-burst");
    base_done = done_count; base_log = rd_log_count;
    applyStimulus(1'b0, 4'd2, 5'd5);
    next_cycle();
    next_cycle();
    next_cycle();
    #2;
    arst_in = 1'b1;
    #1;
    checkOutput("mid_words_before_reset", rd_log_count - base_log, 2);
    checkOutput("mid_word0", rd_log[base_log], 16'h5502);
    checkOutput("mid_word1", rd_log[base_log + 1], 16'h5503);
    checkOutput("mid_rst_rd_valid", bus.rd_valid, 0);
    checkOutput("mid_rst_rd_last", bus.rd_last, 0);
    checkOutput("mid_rst_rd_data", bus.rd_data, 0);
    checkOutput("mid_rst_read_en", bus.mem_read_en, 0);
    checkOutput("mid_rst_cmd_ready", bus.cmd_ready, 0);
    checkOutput("mid_rst_done", bus.done, 0);
    checkOutput("mid_rst_raddr", bus.mem_read_addr, 0);
    @(posedge clk);
    @(negedge clk);
    arst_in = 1'b0;
    #1;
    checkOutput("mid_release_cmd_ready", bus.cmd_ready, 1);
    next_cycle();
    next_cycle();
    checkOutput("mid_no_done", done_count - base_done, 0);

    bus.wr_valid = 1'b1;
    bus.wr_data  = 16'h1234;
    applyStimulus(1'b1, 4'd5, 5'd2);
    @(negedge clk);
    checkOutput("post_wr_en0", bus.mem_write_en, 1);
    checkOutput("post_wr_addr0", bus.mem_write_addr, 5);
    next_cycle();
    bus.wr_data = 16'h5678;
    @(negedge clk);
    checkOutput("post_wr_en1", bus.mem_write_en, 1);
    checkOutput("post_wr_addr1", bus.mem_write_addr, 6);
    next_cycle();
    bus.wr_valid = 1'b0;
    @(negedge clk);
    checkOutput("post_wr_done", bus.done, 1);
    next_cycle();
    @(negedge clk);
    checkOutput("post_wr_cmd_ready", bus.cmd_ready, 1);
    checkOutput("post_wr_mem5", mem[5], 16'h1234);
    checkOutput("post_wr_mem6", mem[6], 16'h5678);
    checkOutput("post_wr_done_total", done_count - base_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_burst_master.md
# mem_burst_master

Initiator for the team's pseudo-2-port `memory` block. It accepts one burst command (direction, base address, length) and runs it to completion:
- **Read burst:** streams the addressed words out on a valid/ready read stream.
- **Write burst:** sinks a valid/ready write stream into consecutive memory words.

It sits between compute/datapath blocks and any `memory` instance, internal or external. It drives that memory's read and write ports directly, with no glue logic.

## Interface
- `WIDTH`, 16, data word width; must match the attached memory.
- `HEIGHT`, 1024, depth of the attached memory; `ADDR_W = $clog2(HEIGHT)`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `arst_in`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_write`  in  1  1 = write burst, 0 = read burst.
- `cmd_addr`  in  `ADDR_W`  base address.
- `cmd_len`  in  `ADDR_W+1`  number of words; 0 is legal.
- `rd_data`  out  `WIDTH`  read stream data (registered).
- `rd_valid`  out  1  read stream valid.
- `rd_last`  out  1  marks the final word of a read burst.
- `rd_ready`  in  1  read stream consumer ready.
- `wr_data`  in  `WIDTH`  write stream data.
- `wr_valid`  in  1  write stream valid.
- `wr_ready`  out  1  write stream ready.
- `done`  out  1  one-cycle pulse after a burst completes.
- `mem_read_addr`  out  `ADDR_W`  to memory `read_addr`.
- `mem_read_en`  out  1  to memory `read_en`.
- `mem_qout`  in  `WIDTH`  from memory `qout`; combinational, same cycle.
- `mem_write_addr`  out  `ADDR_W`  to memory `write_addr`.
- `mem_din`  out  `WIDTH`  to memory `din`.
- `mem_write_en`  out  1  to memory `write_en`.

## Operation
- **States:** IDLE, READ, WRITE, DONE.
- **Registers:**
  - `addr` (`ADDR_W` bits);
  - `issued` and `remaining` counters (`ADDR_W+1` bits each);
  - output register holding `rd_data`, `rd_valid`, `rd_last`.
- **IDLE:**
  - `cmd_ready=1`.
  - On handshake, latch `addr=cmd_addr`, `remaining=cmd_len`, `issued=0`.
  - `cmd_len==0` → DONE; otherwise → READ or WRITE according to `cmd_write`.
- **Address stepping:** `addr` increments by 1 per memory access and wraps modulo `HEIGHT` (`HEIGHT-1` → 0, including for non-power-of-2 `HEIGHT`). A `cmd_len` greater than `HEIGHT` therefore revisits addresses.
- **READ:**
  - `mem_read_addr=addr`.
  - `mem_read_en = (issued<remaining) && (!rd_valid || rd_ready)`.
  - On an edge with `mem_read_en=1`: `rd_data<=mem_qout`, `rd_valid<=1`, `rd_last<=(issued==remaining-1)`, `issued++`, `addr++`.
  - On an edge where `rd_valid && rd_ready` and no new read is issued: `rd_valid<=0`.
  - After the handshake of the word with `rd_last=1` → DONE, with `rd_valid` cleared.
  - Each word is read from memory exactly once; `mem_read_en` is never asserted speculatively, because memory energy is counted per enable.
- **WRITE:**
  - `wr_ready = (remaining!=0)`.
  - `mem_write_en = wr_valid && wr_ready`, with `mem_write_addr=addr` and `mem_din=wr_data`, combinational pass-through.
  - Each accepted word: `addr++`, `remaining--`.
  - The edge at which `remaining` goes from 1 to 0 → DONE.
- **DONE:** `done=1`, `cmd_ready=0`; next edge → IDLE.
- **Outside READ:** `mem_read_en=0`. **Outside WRITE:** `mem_write_en=0` and `wr_ready=0`. `mem_read_addr` and `mem_write_addr` equal `addr` in all states.
- **Reset (asynchronous, any time including mid-burst):**
  - state=IDLE; `addr`, counters and `rd_data` = 0; `rd_valid=0`, `rd_last=0`.
  - `done=0`, `cmd_ready=1` while not in reset (`cmd_ready=0` during reset).
  - `mem_read_en=0`, `mem_write_en=0`, `wr_ready=0` immediately on reset assertion.
  - The in-flight burst is abandoned; no `done` pulse is emitted for it.

## Timing
- **Command acceptance:** command accepted at edge E0. The first `mem_read_en`/`wr_ready` is visible in the cycle after E0.
- **Read latency:** the first `rd_valid=1` appears after edge E1.
- **Read throughput:** 1 word/cycle with `rd_ready` held high. `rd_valid`, `rd_data` and `rd_last` are held stable while `rd_valid && !rd_ready`.
- **Write latency:** 0 cycles from stream handshake to memory write edge. Throughput 1 word/cycle.
- **Completion:** `done` is high in the cycle after the last stream handshake. `cmd_ready` returns 1 one cycle after that.
- **Zero-length command:** `cmd_len=0` gives `done` in the cycle after E0 with no memory enables.
- **Back-to-back bursts:** the minimum gap between command acceptances is burst length + 2 cycles.

## Test plan
- **Reset:** assert `arst_in` mid-cycle → all outputs go to the reset values listed above immediately; `cmd_ready=1` after release.
- **Read burst:** preload mem[10..13] = `0xA0..0xA3`, read addr=10 len=4, `rd_ready=1` → `rd_data` = `A0,A1,A2,A3` on 4 consecutive cycles starting the 2nd cycle after acceptance. `rd_last` only on `A3`; `done` the next cycle; exactly 4 `mem_read_en` cycles.
- **Read backpressure:** same burst with `rd_ready` pattern 1,0,0,1,0,1,1 → no duplicated or lost words; data held stable while stalled; `mem_read_en` asserted exactly 4 cycles in total.
- **Write wrap:** `HEIGHT=16`, write addr=14 len=4, `wr_data` 1..4 with `wr_valid` gapped → memory addresses 14,15,0,1 hold 1,2,3,4; `wr_ready` drops after the 4th word.
- **Zero length:** `cmd_len=0`, both directions → `done` in the cycle after acceptance; no `mem_read_en` or `mem_write_en`.
- **Reset mid-burst:** `arst_in` asserted after 2 of 5 read words → no `done` pulse; a following write burst of len=2 completes normally.
